// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial adder/subtractor.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple adder made of NAND-only full-adder cells.
module nibble_add_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    logic [NIB_W:0] carry;

    always_comb begin
        logic n1, n2, n3, s1, n4, n5, n6;
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            // Nine-NAND full adder: first half-adder, then second half-adder with carry merge.
            n1           = nand2(a[i], b[i]);
            n2           = nand2(a[i], n1);
            n3           = nand2(b[i], n1);
            s1           = nand2(n2, n3);
            n4           = nand2(s1, carry[i]);
            n5           = nand2(s1, n4);
            n6           = nand2(carry[i], n4);
            sum[i]       = nand2(n5, n6);
            carry[i + 1] = nand2(n1, n4);
        end
        cout = carry[NIB_W];
        c3   = carry[NIB_W-1];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder/subtractor processing one nibble per clock, LSB first, with
// valid/ready handshakes on operands and result.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic                 sub_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum_out,
    output logic                 cout_out,
    output logic                 ovf_out
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state, state_n;
    logic [W-1:0]     a_reg, b_reg, acc, acc_n;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             load, step, last;

    logic [W-1:0]     a_sh, b_sh, shift_mask, shift_sum;
    logic [IDX_W+1:0] bit_pos;
    logic [3:0]       slice_sum;
    logic             slice_cout, slice_c3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Nibble selection: shift the current nibble down to bit 0 for the slice.
    assign last    = (idx == LAST_IDX);
    assign bit_pos = {idx, 2'b00};
    assign a_sh    = a_reg >> bit_pos;
    assign b_sh    = b_reg >> bit_pos;

    nibble_add_slice u_slice (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign shift_mask = W'(4'hF) << bit_pos;
    assign shift_sum  = W'(slice_sum) << bit_pos;
    assign acc_n      = (acc & ~shift_mask) | shift_sum;

    // Partial sums live in acc; sum_out only changes when the last nibble lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            ovf_out  <= 1'b0;
        end else if (load) begin
            a_reg <= a_in;
            b_reg <= sub_in ? ~b_in : b_in;
            acc   <= '0;
            idx   <= '0;
            carry <= sub_in;
        end else if (step) begin
            acc   <= acc_n;
            carry <= slice_cout;
            if (last) begin
                sum_out  <= acc_n;
                cout_out <= slice_cout;
                ovf_out  <= slice_c3 ^ slice_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES = 4.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        sub_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_out;
    logic        cout_out;
    logic        ovf_out;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until out_valid, bounded at 20.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
        int lat;
        a_in     = a;
        b_in     = b;
        sub_in   = sub;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a_in     = 16'hDEAD;
        b_in     = 16'hBEEF;
        sub_in   = ~sub;
        wait_result(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout_out), 32'(exp_cout));
        check({tag, "_ovf"}, 32'(ovf_out), 32'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int spurious;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sub_in    = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout_out), 32'd0);
        check("rst_ovf", 32'(ovf_out), 32'd0);
        rst = 1'b0;
        tick();

        do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_5m7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result held while new operands wait on in_valid.
        a_in = 16'h1234; b_in = 16'h1111; sub_in = 1'b0; in_valid = 1'b1;
        tick();
        a_in = 16'h0F0F; b_in = 16'h0101; sub_in = 1'b0; in_valid = 1'b1;
        wait_result(lat);
        check("bp_first_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_sum", 32'(sum_out), 32'h2345);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        check("bp_second_latency", 32'(lat), 32'd4);
        check("bp_second_sum", 32'(sum_out), 32'h1010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN, at nibble index 2.
        a_in = 16'h4444; b_in = 16'h1111; sub_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum_out), 32'd0);
        check("mid_rst_cout", 32'(cout_out), 32'd0);
        check("mid_rst_ovf", 32'(ovf_out), 32'd0);
        tick();
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) spurious++;
        end
        check("mid_rst_no_valid", 32'(spurious), 32'd0);
        check("mid_rst_idle", 32'(in_ready), 32'd1);
        do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder/subtractor built around a 4-bit ripple slice, one nibble per clock, LSB first.
- Carry is held in a register between nibbles.
- Sits between operand-producing logic and result consumers, reusing the team's 4-bit adder datapath for N×4-bit operands.
- Valid/ready handshake on both input and output.

Parameters:
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept operands.
- a_in  input  W  operand A.
- b_in  input  W  operand B.
- sub_in  input  1  0 = A+B; 1 = A−B (two's complement).
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- sum_out  output  W  result.
- cout_out  output  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf_out  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: all outputs go to 0 asynchronously, except in_ready = 1. State = IDLE, all internal registers cleared.
- States: IDLE, RUN, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- IDLE, on in_valid & in_ready:
  - Latch A.
  - Latch B, inverted when sub_in = 1.
  - Set carry register = sub_in and nibble index = 0.
  - Go to RUN.
- RUN, each cycle:
  - Slice adds A[idx], B[idx] and the carry register.
  - Sum nibble is written to result[idx]; carry register <= slice cout.
  - At idx = NIBBLES−1, also capture cout_out and ovf_out (slice exposes the carry into bit 3), then go to DONE.
  - Otherwise idx increments.
- Latency: handshake in cycle 0 → out_valid high in cycle NIBBLES.
- DONE:
  - sum_out, cout_out and ovf_out are stable while out_valid = 1 and out_ready = 0.
  - On out_ready, go to IDLE. out_valid drops next cycle; in_ready rises next cycle.
  - No same-cycle re-accept: minimum initiation interval is NIBBLES+2 cycles.
- in_valid during RUN/DONE is ignored; operands are not sampled.
- Operand inputs may change freely after the accepting edge.
- sum_out is updated only at the RUN→DONE transition. It holds its last value in IDLE, is 0 after reset, and never shows partial results.
- Arithmetic is modulo 2^W; no saturation.
- rst asserted mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it, and in_ready = 1 once rst deasserts.
- Index counter width = clog2(NIBBLES). It never wraps past NIBBLES−1.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - nibble width constant (4).
- Sub-module: nibble_add_slice.
  - Combinational 4-bit ripple adder of NAND-built full-adder cells.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout, c3 (carry into bit 3).
  - Exactly one instance in the top block.

Test Plan (NIBBLES = 4):
- Add 0x00FF + 0x0001, sub = 0:
  - sum_out = 0x0100, cout = 0, ovf = 0.
  - out_valid rises exactly 4 cycles after the accepting edge.
- Add 0xFFFF + 0x0001 → sum = 0x0000, cout = 1, ovf = 0.
- Add 0x7FFF + 0x0001 → sum = 0x8000, cout = 0, ovf = 1.
- Subtract:
  - 0x0005 − 0x0007 → sum = 0xFFFE, cout = 0 (borrow), ovf = 0.
  - 0x8000 − 0x0001 → sum = 0x7FFF, cout = 1, ovf = 1.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles in DONE with in_valid = 1 and new operands.
  - Outputs stay stable and in_ready stays 0.
  - The second operation is accepted only in the cycle after IDLE is re-entered.
- Reset mid-RUN:
  - Assert rst at idx = 2 for 1 cycle.
  - All outputs 0 and in_ready = 1 immediately.
  - No out_valid follows; the next operation computes correctly.
